// File: rtl/net_pkg.sv
// Shared types and constants for the network output stage.
// Optional slew clamp is enabled by defining NET_OUT_SLEW_EN.
package net_pkg;
  localparam int W_DEF = 16;
  localparam int N_CH  = 4;

  // Saturation bounds for the default sample width.
  localparam logic signed [W_DEF-1:0] SAT_MAX = 16'sh7FFF;
  localparam logic signed [W_DEF-1:0] SAT_MIN = 16'sh8000;

  typedef enum logic [1:0] {
    IDLE,
    PROC,
    COMMIT
  } state_e;
endpackage

// File: rtl/net_sat_slew.sv
// Single-channel shift + saturate, with optional per-frame slew clamp
// (NET_OUT_SLEW_EN). Purely combinational; time-shared across channels.
module net_sat_slew
  import net_pkg::*;
#(
  parameter int W         = W_DEF,
  parameter int SHIFT     = 2,
  parameter int SLEW_STEP = 512
) (
  input  logic signed [W-1:0] in_val,
  input  logic signed [W-1:0] prev,
  output logic signed [W-1:0] res,
  output logic                sat
);
  localparam int WS = W + SHIFT;
  localparam logic signed [WS-1:0] HI = {{(SHIFT+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [WS-1:0] LO = {{(SHIFT+1){1'b1}}, {(W-1){1'b0}}};

  logic signed [WS-1:0] s_wide;
  logic signed [W-1:0]  s_sat;

  always_comb begin
    // Sign-extend by SHIFT first so the shift itself can never overflow.
    s_wide = $signed({{SHIFT{in_val[W-1]}}, in_val}) <<< SHIFT;
    sat    = 1'b1;
    if (s_wide > HI)      s_sat = HI[W-1:0];
    else if (s_wide < LO) s_sat = LO[W-1:0];
    else begin
      s_sat = s_wide[W-1:0];
      sat   = 1'b0;
    end
  end

`ifdef NET_OUT_SLEW_EN
  localparam logic signed [W:0] STEP = (W+1)'(SLEW_STEP);
  logic signed [W:0] d, dc, r;

  always_comb begin
    d = {s_sat[W-1], s_sat} - {prev[W-1], prev};
    if (d > STEP)       dc = STEP;
    else if (d < -STEP) dc = -STEP;
    else                dc = d;
    // Result lies between prev and s_sat, so it always fits in W bits.
    r   = {prev[W-1], prev} + dc;
    res = r[W-1:0];
  end
`else
  logic unused_slew;
  assign unused_slew = ^{prev, SLEW_STEP};
  assign res = s_sat;
`endif
endmodule

// File: rtl/net_output_stage.sv
// Frame-aligns network results to the codec strobe: pending bank, 4-cycle
// shared rescale datapath, simultaneous commit, underrun counting.
module net_output_stage
  import net_pkg::*;
#(
  parameter int W         = W_DEF,
  parameter int SHIFT     = 2,
  parameter int SLEW_STEP = 512
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sample_clk,
  input  logic                in_valid,
  input  logic signed [W-1:0] in0,
  input  logic signed [W-1:0] in1,
  input  logic signed [W-1:0] in2,
  input  logic signed [W-1:0] in3,
  input  logic                mute,
  output logic signed [W-1:0] out0,
  output logic signed [W-1:0] out1,
  output logic signed [W-1:0] out2,
  output logic signed [W-1:0] out3,
  output logic                out_v,
  output logic [N_CH-1:0]     sat_flags,
  output logic [15:0]         underruns
);
  typedef logic [N_CH-1:0][W-1:0] bank_t;

  state_e      state_q, state_d;
  logic [1:0]  ch_q, ch_d;
  logic        pend_q, pend_d;
  logic        prev_sclk_q, prev_sclk_d;
  bank_t       pend_bank_q, pend_bank_d;
  bank_t       work_q, work_d;
  bank_t       next_q, next_d;
  bank_t       out_q, out_d;
  logic        out_v_q, out_v_d;
  logic [N_CH-1:0] sat_q, sat_d;
  logic [15:0] under_q, under_d;

  bank_t          in_bank;
  logic           sclk_edge;
  logic           under_inc;
  logic [W-1:0]   dp_res;
  logic           dp_sat;

  assign in_bank   = {in3, in2, in1, in0};
  assign sclk_edge = sample_clk & ~prev_sclk_q;

  net_sat_slew #(
    .W         (W),
    .SHIFT     (SHIFT),
    .SLEW_STEP (SLEW_STEP)
  ) u_dp (
    .in_val (work_q[ch_q]),
    .prev   (out_q[ch_q]),
    .res    (dp_res),
    .sat    (dp_sat)
  );

  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    pend_d      = pend_q;
    prev_sclk_d = sample_clk;
    pend_bank_d = pend_bank_q;
    work_d      = work_q;
    next_d      = next_q;
    out_d       = out_q;
    out_v_d     = 1'b0;
    sat_d       = sat_q;
    under_inc   = 1'b0;

    // Latest result wins; a frame start below may consume it immediately.
    if (in_valid) begin
      pend_bank_d = in_bank;
      pend_d      = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (sclk_edge) begin
          if (in_valid || pend_q) begin
            work_d  = in_valid ? in_bank : pend_bank_q;
            pend_d  = 1'b0;
            ch_d    = 2'd0;
            state_d = PROC;
          end else begin
            under_inc = 1'b1;
          end
        end
      end
      PROC: begin
        if (sclk_edge) under_inc = 1'b1;
        next_d[ch_q] = dp_res;
        if (dp_sat) sat_d[ch_q] = 1'b1;
        ch_d = ch_q + 2'd1;
        if (ch_q == 2'd3) state_d = COMMIT;
      end
      COMMIT: begin
        if (sclk_edge) under_inc = 1'b1;
        out_d   = mute ? '0 : next_q;
        out_v_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    under_d = under_q;
    if (under_inc && (under_q != 16'hFFFF)) under_d = under_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ch_q        <= 2'd0;
      pend_q      <= 1'b0;
      prev_sclk_q <= 1'b0;
      pend_bank_q <= '0;
      work_q      <= '0;
      next_q      <= '0;
      out_q       <= '0;
      out_v_q     <= 1'b0;
      sat_q       <= '0;
      under_q     <= '0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      pend_q      <= pend_d;
      prev_sclk_q <= prev_sclk_d;
      pend_bank_q <= pend_bank_d;
      work_q      <= work_d;
      next_q      <= next_d;
      out_q       <= out_d;
      out_v_q     <= out_v_d;
      sat_q       <= sat_d;
      under_q     <= under_d;
    end
  end

  assign out0      = out_q[0];
  assign out1      = out_q[1];
  assign out2      = out_q[2];
  assign out3      = out_q[3];
  assign out_v     = out_v_q;
  assign sat_flags = sat_q;
  assign underruns = under_q;
endmodule

// File: tb/tb_net_output_stage.sv
// Directed bench for net_output_stage; expected values hand-computed for
// both slew-off (default) and NET_OUT_SLEW_EN builds.
module tb_net_output_stage;
  import net_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sample_clk = 1'b0;
  logic in_valid = 1'b0;
  logic mute = 1'b0;
  logic signed [15:0] in0 = '0, in1 = '0, in2 = '0, in3 = '0;
  logic signed [15:0] out0, out1, out2, out3;
  logic        out_v;
  logic [3:0]  sat_flags;
  logic [15:0] underruns;

  int vectors = 0;
  int errors  = 0;
  int pcnt, ppos;

  net_output_stage #(.W(16), .SHIFT(2), .SLEW_STEP(512)) dut (
    .clk(clk), .rst_n(rst_n), .sample_clk(sample_clk), .in_valid(in_valid),
    .in0(in0), .in1(in1), .in2(in2), .in3(in3), .mute(mute),
    .out0(out0), .out1(out1), .out2(out2), .out3(out3), .out_v(out_v),
    .sat_flags(sat_flags), .underruns(underruns)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [15:0] e0, e1, e2, e3);
    chk({tag, ".out0"}, out0, e0);
    chk({tag, ".out1"}, out1, e1);
    chk({tag, ".out2"}, out2, e2);
    chk({tag, ".out3"}, out3, e3);
  endtask

  task automatic load(input logic [15:0] a, b, c, d);
    in_valid = 1'b1; in0 = a; in1 = b; in2 = c; in3 = d;
    tick(1);
    in_valid = 1'b0;
  endtask

  // Raise the strobe, then watch out_v for 6 cycles after the capturing edge.
  task automatic frame();
    sample_clk = 1'b1;
    tick(1);
    sample_clk = 1'b0;
    pcnt = 0; ppos = 0;
    for (int i = 1; i <= 6; i++) begin
      tick(1);
      if (out_v) begin pcnt++; ppos = i; end
    end
  endtask

  initial begin
    tick(2);
    chk_outs("reset", 16'h0, 16'h0, 16'h0, 16'h0);
    chk("reset.out_v", {15'b0, out_v}, 16'h0);
    chk("reset.sat", {12'b0, sat_flags}, 16'h0);
    chk("reset.under", underruns, 16'h0);
    @(negedge clk); rst_n = 1'b1;
    tick(2);

    // Edge with nothing pending
    frame();
    chk("under1.pulses", 16'(pcnt), 16'd0);
    chk("under1.count", underruns, 16'd1);
    chk("under1.out0", out0, 16'h0);

    // Basic in-range frame
    load(16'h0100, 16'hFF00, 16'h0001, 16'h0000);
    frame();
    chk("f1.pulses", 16'(pcnt), 16'd1);
    chk("f1.latency", 16'(ppos), 16'd5);
`ifdef NET_OUT_SLEW_EN
    chk_outs("f1", 16'h0200, 16'hFE00, 16'h0004, 16'h0000);
`else
    chk_outs("f1", 16'h0400, 16'hFC00, 16'h0004, 16'h0000);
`endif
    chk("f1.sat", {12'b0, sat_flags}, 16'h0);

    // Overflow both directions
    load(16'h3000, 16'hD000, 16'h0010, 16'h0FFF);
    frame();
    chk("f2.pulses", 16'(pcnt), 16'd1);
`ifdef NET_OUT_SLEW_EN
    chk_outs("f2", 16'h0400, 16'hFC00, 16'h0040, 16'h0200);
`else
    chk_outs("f2", SAT_MAX, SAT_MIN, 16'h0040, 16'h3FFC);
`endif
    chk("f2.sat", {12'b0, sat_flags}, 16'h0003);

    // In-range frame: flags stay sticky
    load(16'h0100, 16'h0100, 16'h0000, 16'h0000);
    frame();
`ifdef NET_OUT_SLEW_EN
    chk_outs("f3", 16'h0400, 16'hFE00, 16'h0000, 16'h0000);
`else
    chk_outs("f3", 16'h0400, 16'h0400, 16'h0000, 16'h0000);
`endif
    chk("f3.sat", {12'b0, sat_flags}, 16'h0003);

    // Mute frame
    mute = 1'b1;
    load(16'h0100, 16'h0100, 16'h0100, 16'h0100);
    frame();
    mute = 1'b0;
    chk("mute.pulses", 16'(pcnt), 16'd1);
    chk_outs("mute", 16'h0, 16'h0, 16'h0, 16'h0);

    // Bypass: data arrives in the edge cycle; second edge 3 cycles later ignored
    in_valid = 1'b1; in0 = 16'h0010; in1 = 16'h0020; in2 = 16'h0030; in3 = 16'h0040;
    sample_clk = 1'b1;
    tick(1);
    in_valid = 1'b0; sample_clk = 1'b0;
    pcnt = 0; ppos = 0;
    for (int i = 1; i <= 6; i++) begin
      if (i == 3) sample_clk = 1'b1;
      if (i == 4) sample_clk = 1'b0;
      tick(1);
      if (out_v) begin pcnt++; ppos = i; end
    end
    chk("byp.pulses", 16'(pcnt), 16'd1);
    chk("byp.latency", 16'(ppos), 16'd5);
    chk_outs("byp", 16'h0040, 16'h0080, 16'h00C0, 16'h0100);
    chk("byp.under", underruns, 16'd2);

    // Bypass left nothing pending
    frame();
    chk("nopend.pulses", 16'(pcnt), 16'd0);
    chk("nopend.under", underruns, 16'd3);
    chk("nopend.hold", out3, 16'h0100);

    // Reset during PROC
    load(16'h0200, 16'h0200, 16'h0200, 16'h0200);
    sample_clk = 1'b1;
    tick(1);
    sample_clk = 1'b0;
    tick(2);
    rst_n = 1'b0;
    #1;
    chk_outs("rstmid", 16'h0, 16'h0, 16'h0, 16'h0);
    chk("rstmid.out_v", {15'b0, out_v}, 16'h0);
    chk("rstmid.sat", {12'b0, sat_flags}, 16'h0);
    chk("rstmid.under", underruns, 16'h0);
    @(negedge clk); rst_n = 1'b1;
    pcnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      if (out_v) pcnt++;
    end
    chk("rstmid.nopulse", 16'(pcnt), 16'd0);
    frame();
    chk("rstmid.edge.pulses", 16'(pcnt), 16'd0);
    chk("rstmid.edge.under", underruns, 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
